// File: rtl/multi_edge_det_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : multi_edge_det_pkg
//  Purpose  : Shared types for the multi-channel edge detector: channel mode
//             encoding, per-channel filter FSM states and the filter counter
//             width helper.
//  Revision : 1.0  initial release
// ============================================================================
package multi_edge_det_pkg;

    // Per-channel pulse mode: bit0 enables rise pulses, bit1 fall pulses.
    typedef enum logic [1:0] {
        MODE_OFF  = 2'b00,
        MODE_RISE = 2'b01,
        MODE_FALL = 2'b10,
        MODE_BOTH = 2'b11
    } mode_e;

    // Glitch filter states. The accepted level is 1 in ST_HIGH/ST_CONFIRM_LOW.
    typedef enum logic [1:0] {
        ST_LOW          = 2'b00,
        ST_CONFIRM_HIGH = 2'b01,
        ST_HIGH         = 2'b10,
        ST_CONFIRM_LOW  = 2'b11
    } filt_state_e;

    // Width of a counter that must hold values 0..filter_len.
    function automatic int filt_cnt_w(input int filter_len);
        return $clog2(filter_len + 1);
    endfunction

endpackage : multi_edge_det_pkg
`default_nettype wire

// File: rtl/edge_filter_ch.sv
`default_nettype none
// ============================================================================
//  Module   : edge_filter_ch
//  Purpose  : One detector channel: input synchroniser, glitch filter FSM and
//             registered one-cycle rise/fall pulse generation.
//  Ports    : clk, rst (async, active-high)
//             en         - global enable for pulse emission
//             din        - raw asynchronous input
//             mode[1:0]  - bit0 rise enable, bit1 fall enable
//             level      - filtered, synchronised level
//             rise_pulse / fall_pulse - registered 1-cycle pulses
//             rise_set / fall_set     - combinational "pulse will be emitted
//                                       at this edge" (used by the top to set
//                                       flags and counters on the same edge)
//  Revision : 1.0  initial release
// ============================================================================
module edge_filter_ch
    import multi_edge_det_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       din,
    input  logic [1:0] mode,
    output logic       level,
    output logic       rise_pulse,
    output logic       fall_pulse,
    output logic       rise_set,
    output logic       fall_set
);

    localparam int                 c_CNT_W = filt_cnt_w(FILTER_LEN);
    // The flip happens when the incoming differing sample would make the
    // count reach FILTER_LEN, so the stored count never exceeds FILTER_LEN-1.
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(FILTER_LEN - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_synced;
    filt_state_e            r_state, w_state_nxt;
    logic [c_CNT_W-1:0]     r_cnt, w_cnt_nxt;
    logic                   w_up, w_dn;
    mode_e                  w_mode;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_sync <= '0;
        else     r_sync <= {r_sync[SYNC_STAGES-2:0], din};
    end

    assign w_synced = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_LOW;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_up        = 1'b0;
        w_dn        = 1'b0;
        case (r_state)
            ST_LOW, ST_CONFIRM_HIGH: begin
                if (w_synced) begin
                    if (r_cnt == c_LAST) begin
                        w_state_nxt = ST_HIGH;
                        w_cnt_nxt   = '0;
                        w_up        = 1'b1;
                    end else begin
                        w_state_nxt = ST_CONFIRM_HIGH;
                        w_cnt_nxt   = r_cnt + c_CNT_W'(1);
                    end
                end else begin
                    w_state_nxt = ST_LOW;
                    w_cnt_nxt   = '0;
                end
            end
            ST_HIGH, ST_CONFIRM_LOW: begin
                if (!w_synced) begin
                    if (r_cnt == c_LAST) begin
                        w_state_nxt = ST_LOW;
                        w_cnt_nxt   = '0;
                        w_dn        = 1'b1;
                    end else begin
                        w_state_nxt = ST_CONFIRM_LOW;
                        w_cnt_nxt   = r_cnt + c_CNT_W'(1);
                    end
                end else begin
                    w_state_nxt = ST_HIGH;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = ST_LOW;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign w_mode   = mode_e'(mode);
    assign rise_set = w_up & en & ((w_mode == MODE_RISE) || (w_mode == MODE_BOTH));
    assign fall_set = w_dn & en & ((w_mode == MODE_FALL) || (w_mode == MODE_BOTH));
    assign level    = (r_state == ST_HIGH) || (r_state == ST_CONFIRM_LOW);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
        end else begin
            rise_pulse <= rise_set;
            fall_pulse <= fall_set;
        end
    end

endmodule : edge_filter_ch
`default_nettype wire

// File: rtl/multi_edge_detector.sv
`default_nettype none
// ============================================================================
//  Module   : multi_edge_detector
//  Purpose  : Multi-channel synchronising, glitch-filtering edge detector with
//             per-channel mode, sticky event flags and a masked, registered
//             interrupt.
//  Ports    : clk, rst (async, active-high), en, din[CHANNELS],
//             mode[2*CHANNELS], level, rise_pulse, fall_pulse, evt_flag,
//             flag_clr, irq_mask, irq
//  Option   : MED_EVT_CNT_EN - adds saturating per-channel event counters
//             (evt_cnt[CHANNELS*CNT_W], cnt_clr).
//  Revision : 1.0  initial release
// ============================================================================
module multi_edge_detector
    import multi_edge_det_pkg::*;
#(
    parameter int CHANNELS    = 8,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 3
`ifdef MED_EVT_CNT_EN
    ,
    parameter int CNT_W       = 8
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [CHANNELS-1:0]   din,
    input  logic [2*CHANNELS-1:0] mode,
    output logic [CHANNELS-1:0]   level,
    output logic [CHANNELS-1:0]   rise_pulse,
    output logic [CHANNELS-1:0]   fall_pulse,
    output logic [CHANNELS-1:0]   evt_flag,
    input  logic [CHANNELS-1:0]   flag_clr,
    input  logic [CHANNELS-1:0]   irq_mask,
    output logic                  irq
`ifdef MED_EVT_CNT_EN
    ,
    output logic [CHANNELS*CNT_W-1:0] evt_cnt,
    input  logic                      cnt_clr
`endif
);

    logic [CHANNELS-1:0] w_rise_set, w_fall_set, w_emit;
    logic [CHANNELS-1:0] r_evt_flag;
    logic                r_irq;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        edge_filter_ch #(
            .SYNC_STAGES (SYNC_STAGES),
            .FILTER_LEN  (FILTER_LEN)
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .en         (en),
            .din        (din[i]),
            .mode       (mode[2*i +: 2]),
            .level      (level[i]),
            .rise_pulse (rise_pulse[i]),
            .fall_pulse (fall_pulse[i]),
            .rise_set   (w_rise_set[i]),
            .fall_set   (w_fall_set[i])
        );

`ifdef MED_EVT_CNT_EN
        logic [CNT_W-1:0] r_evt_cnt;

        // Clear takes priority over increment, but an event on the clearing
        // edge is still counted, leaving the counter at 1.
        always_ff @(posedge clk or posedge rst) begin
            if (rst)
                r_evt_cnt <= '0;
            else if (cnt_clr)
                r_evt_cnt <= w_emit[i] ? CNT_W'(1) : '0;
            else if (w_emit[i] && (r_evt_cnt != {CNT_W{1'b1}}))
                r_evt_cnt <= r_evt_cnt + CNT_W'(1);
        end

        assign evt_cnt[i*CNT_W +: CNT_W] = r_evt_cnt;
`endif
    end

    assign w_emit = w_rise_set | w_fall_set;

    // Flags are set on the same edge that registers the pulse; a set on the
    // clearing edge wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_evt_flag <= '0;
            r_irq      <= 1'b0;
        end else begin
            r_evt_flag <= (r_evt_flag & ~flag_clr) | w_emit;
            r_irq      <= |(r_evt_flag & irq_mask);
        end
    end

    assign evt_flag = r_evt_flag;
    assign irq      = r_irq;

endmodule : multi_edge_detector
`default_nettype wire
